// File: rtl/hms_pkg.sv
// Shared types and constants for the hour:min:sec timekeeping core.
package hms_pkg;

    typedef enum logic {
        MODE_CLOCK = 1'b0,
        MODE_SETUP = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        POS_SEC  = 2'd0,
        POS_MIN  = 2'd1,
        POS_HOUR = 2'd2
    } pos_t;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    // Single-field +1/-1 with wrap at both ends and no carry out.
    function automatic logic [5:0] step_wrap(input logic [5:0] v,
                                             input logic [5:0] max,
                                             input logic       up);
        if (up) begin
            return (v >= max) ? 6'd0 : v + 6'd1;
        end
        return (v == 6'd0) ? max : v - 6'd1;
    endfunction

endpackage

// File: rtl/hms_clock_core_btn_pulse.sv
// Button conditioning: 2-flop synchroniser, 3-sample history, one-clk press pulse.
module btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic i_sample_en,
    input  logic i_raw,
    output logic o_press
);

    logic [1:0] sync;
    logic [2:0] hist;

    // Reset to "held" so a button kept down through reset never reads as a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            hist <= 3'b111;
        end else begin
            sync <= {sync[0], i_raw};
            if (i_sample_en) begin
                hist <= {hist[1:0], sync[1]};
            end
        end
    end

    assign o_press = i_sample_en && ({hist[1:0], sync[1]} == 3'b011);

endmodule

// File: rtl/hms_clock_core.sv
// Hour:min:sec timekeeping core with CLOCK/SETUP modes and 12/24-hour output.
module hms_clock_core
    import hms_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int DB_DIV   = 500000,
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sw_mode,
    input  logic       i_sw_pos,
    input  logic       i_sw_inc,
    input  logic       i_sw_dec,
    input  logic       i_fmt12,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_pm,
    output logic       o_mode,
    output logic [1:0] o_pos,
    output logic       o_tick,
    output logic       o_blink
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_DIV);
    localparam logic [5:0] HOUR_MAX6 = 6'(HOUR_MAX);

    logic [TW-1:0] tick_cnt, tick_cnt_d;
    logic [DW-1:0] db_cnt;
    logic          db_tick;
    logic          tick;

    mode_t      mode_q, mode_d;
    pos_t       pos_q, pos_d;
    logic [5:0] sec_q, sec_d, min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] hour_step;

    logic press_mode, press_pos, press_inc, press_dec;

    assign db_tick = (db_cnt == DW'(DB_DIV - 1));
    assign tick    = (mode_q == MODE_CLOCK) && (tick_cnt == TW'(TICK_DIV - 1));

    btn_pulse u_mode (.clk(clk), .rst(rst), .i_sample_en(db_tick), .i_raw(i_sw_mode), .o_press(press_mode));
    btn_pulse u_pos  (.clk(clk), .rst(rst), .i_sample_en(db_tick), .i_raw(i_sw_pos),  .o_press(press_pos));
    btn_pulse u_inc  (.clk(clk), .rst(rst), .i_sample_en(db_tick), .i_raw(i_sw_inc),  .o_press(press_inc));
    btn_pulse u_dec  (.clk(clk), .rst(rst), .i_sample_en(db_tick), .i_raw(i_sw_dec),  .o_press(press_dec));

    always_comb begin
        mode_d     = mode_q;
        pos_d      = pos_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        hour_step  = 6'd0;
        tick_cnt_d = '0;
        if (mode_q == MODE_CLOCK) begin
            tick_cnt_d = tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                if (sec_q == SEC_MAX) begin
                    sec_d = 6'd0;
                    if (min_q == MIN_MAX) begin
                        min_d  = 6'd0;
                        hour_d = (hour_q == HOUR_MAX6[4:0]) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end
            if (press_mode) begin
                mode_d = MODE_SETUP;
                pos_d  = POS_SEC;
            end
        end else begin
            // Priority mode > pos > inc/dec; inc and dec together cancel.
            if (press_mode) begin
                mode_d = MODE_CLOCK;
            end else if (press_pos) begin
                case (pos_q)
                    POS_SEC: pos_d = POS_MIN;
                    POS_MIN: pos_d = POS_HOUR;
                    default: pos_d = POS_SEC;
                endcase
            end else if (press_inc ^ press_dec) begin
                case (pos_q)
                    POS_SEC: sec_d = step_wrap(sec_q, SEC_MAX, press_inc);
                    POS_MIN: min_d = step_wrap(min_q, MIN_MAX, press_inc);
                    default: begin
                        hour_step = step_wrap({1'b0, hour_q}, HOUR_MAX6, press_inc);
                        hour_d    = hour_step[4:0];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_CLOCK;
            pos_q    <= POS_SEC;
            sec_q    <= 6'd0;
            min_q    <= 6'd0;
            hour_q   <= 5'd0;
            tick_cnt <= '0;
            db_cnt   <= '0;
        end else begin
            mode_q   <= mode_d;
            pos_q    <= pos_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hour_q   <= hour_d;
            tick_cnt <= tick_cnt_d;
            db_cnt   <= db_tick ? '0 : db_cnt + DW'(1);
        end
    end

    always_comb begin
        if (!i_fmt12) begin
            o_hour = hour_q;
        end else if (hour_q == 5'd0) begin
            o_hour = 5'd12;
        end else if (hour_q > 5'd12) begin
            o_hour = hour_q - 5'd12;
        end else begin
            o_hour = hour_q;
        end
    end

    assign o_pm    = i_fmt12 && (hour_q >= 5'd12);
    assign o_sec   = sec_q;
    assign o_min   = min_q;
    assign o_mode  = mode_q;
    assign o_pos   = pos_q;
    assign o_tick  = tick;
    assign o_blink = (mode_q == MODE_SETUP) || (tick_cnt < TW'(TICK_DIV / 2));

endmodule

// File: tb/tb_hms_clock_core.sv
// Directed bench for hms_clock_core with TICK_DIV=4, DB_DIV=2.
module tb_hms_clock_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_mode = 1'b0, sw_pos = 1'b0, sw_inc = 1'b0, sw_dec = 1'b0;
    logic       fmt12 = 1'b0;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic       pm, mode, tick, blink;
    logic [1:0] pos;

    int total = 0;
    int bad   = 0;

    hms_clock_core #(.TICK_DIV(4), .DB_DIV(2), .HOUR_MAX(23)) dut (
        .clk(clk), .rst(rst),
        .i_sw_mode(sw_mode), .i_sw_pos(sw_pos), .i_sw_inc(sw_inc), .i_sw_dec(sw_dec),
        .i_fmt12(fmt12),
        .o_sec(sec), .o_min(min), .o_hour(hour), .o_pm(pm),
        .o_mode(mode), .o_pos(pos), .o_tick(tick), .o_blink(blink)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int   steps;
        int   exp_sec;
        logic exp_tick;
        logic exp_blink;
    } run_vec_t;

    typedef struct {
        int   n_inc;
        logic fmt;
        int   exp_hour;
        logic exp_pm;
    } fmt_vec_t;

    run_vec_t run_tab[7];
    fmt_vec_t fmt_tab[6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: sw_mode = v;
            1: sw_pos  = v;
            2: sw_inc  = v;
            default: sw_dec = v;
        endcase
    endtask

    // Press lands 6 edges after an even-aligned start; 16 cycles keeps alignment.
    task automatic press(input int which);
        set_btn(which, 1'b1);
        step(8);
        set_btn(which, 1'b0);
        step(8);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check({name, ".hour"}, int'(hour), h);
        check({name, ".min"},  int'(min),  m);
        check({name, ".sec"},  int'(sec),  s);
    endtask

    initial begin
        run_tab[0] = '{1, 0, 1'b0, 1'b1};
        run_tab[1] = '{1, 0, 1'b0, 1'b0};
        run_tab[2] = '{1, 0, 1'b1, 1'b0};
        run_tab[3] = '{1, 1, 1'b0, 1'b1};
        run_tab[4] = '{1, 1, 1'b0, 1'b1};
        run_tab[5] = '{3, 2, 1'b0, 1'b1};
        run_tab[6] = '{4, 3, 1'b0, 1'b1};

        fmt_tab[0] = '{0,  1'b1, 12, 1'b0};
        fmt_tab[1] = '{0,  1'b0, 0,  1'b0};
        fmt_tab[2] = '{12, 1'b1, 12, 1'b1};
        fmt_tab[3] = '{0,  1'b0, 12, 1'b0};
        fmt_tab[4] = '{1,  1'b1, 1,  1'b1};
        fmt_tab[5] = '{0,  1'b0, 13, 1'b0};

        // Reset state and free-running seconds.
        fmt12 = 1'b1;
        step(1);
        do_reset();
        check("rst.mode", int'(mode), 0);
        check("rst.pos", int'(pos), 0);
        check("rst.tick", int'(tick), 0);
        check("rst.blink", int'(blink), 1);
        check("rst.hour12", int'(hour), 12);
        check("rst.pm", int'(pm), 0);
        check_time("rst", 12, 0, 0);
        fmt12 = 1'b0;
        #1;
        check("rst.hour24", int'(hour), 0);
        for (int i = 0; i < 7; i++) begin
            step(run_tab[i].steps);
            check($sformatf("run%0d.sec", i), int'(sec), run_tab[i].exp_sec);
            check($sformatf("run%0d.tick", i), int'(tick), int'(run_tab[i].exp_tick));
            check($sformatf("run%0d.blink", i), int'(blink), int'(run_tab[i].exp_blink));
        end

        // Preload 23:59:58 and watch the full rollover.
        do_reset();
        step(4);
        press(0);
        check("pre.mode", int'(mode), 1);
        check("pre.sec", int'(sec), 2);
        repeat (4) press(3);
        check("pre.secwrap", int'(sec), 58);
        press(1);
        press(3);
        press(1);
        press(3);
        check_time("pre", 23, 59, 58);
        sw_mode = 1'b1;
        step(6);
        check("roll.mode", int'(mode), 0);
        check("roll.blink0", int'(blink), 1);
        check_time("roll.a", 23, 59, 58);
        step(2);
        sw_mode = 1'b0;
        step(1);
        check("roll.tick1", int'(tick), 1);
        step(1);
        check_time("roll.b", 23, 59, 59);
        step(3);
        check("roll.tick2", int'(tick), 1);
        check_time("roll.c", 23, 59, 59);
        step(1);
        check_time("roll.d", 0, 0, 0);
        step(8);

        // Setup: field select, hour wrap, 12/24-hour format, button conditioning.
        do_reset();
        step(4);
        press(0);
        check("set.mode", int'(mode), 1);
        check("set.tick", int'(tick), 0);
        check("set.blink", int'(blink), 1);
        press(1);
        check("set.pos1", int'(pos), 1);
        press(1);
        check("set.pos2", int'(pos), 2);
        press(3);
        check("hr.dec", int'(hour), 23);
        check("hr.dec.sec", int'(sec), 2);
        check("hr.dec.min", int'(min), 0);
        press(2);
        check("hr.inc", int'(hour), 0);
        check("hr.inc.sec", int'(sec), 2);
        for (int i = 0; i < 6; i++) begin
            repeat (fmt_tab[i].n_inc) press(2);
            fmt12 = fmt_tab[i].fmt;
            #1;
            check($sformatf("fmt%0d.hour", i), int'(hour), fmt_tab[i].exp_hour);
            check($sformatf("fmt%0d.pm", i), int'(pm), int'(fmt_tab[i].exp_pm));
        end
        press(1);
        check("set.poswrap", int'(pos), 0);
        sw_inc = 1'b1;
        step(20);
        sw_inc = 1'b0;
        step(12);
        check("held.sec", int'(sec), 3);
        sw_inc = 1'b1;
        step(2);
        sw_inc = 1'b0;
        step(14);
        check("glitch.sec", int'(sec), 3);
        sw_inc = 1'b1;
        sw_dec = 1'b1;
        step(8);
        sw_inc = 1'b0;
        sw_dec = 1'b0;
        step(8);
        check("incdec.sec", int'(sec), 3);
        press(3);
        check("dec.sec", int'(sec), 2);
        sw_mode = 1'b1;
        sw_inc  = 1'b1;
        step(6);
        check("modeinc.mode", int'(mode), 0);
        check("modeinc.sec", int'(sec), 2);
        check("modeinc.hour", int'(hour), 13);
        step(2);
        sw_mode = 1'b0;
        sw_inc  = 1'b0;
        step(8);
        press(1);
        check("clk.posign", int'(pos), 0);
        check("clk.mode", int'(mode), 0);

        // Reset in the middle of setup, with the mode button held through it.
        do_reset();
        step(4);
        press(0);
        press(1);
        repeat (23) press(3);
        check("mid.min", int'(min), 37);
        check("mid.pos", int'(pos), 1);
        check("mid.mode", int'(mode), 1);
        sw_mode = 1'b1;
        rst = 1'b1;
        step(1);
        check("rst2.mode", int'(mode), 0);
        check("rst2.pos", int'(pos), 0);
        check("rst2.tick", int'(tick), 0);
        check("rst2.blink", int'(blink), 1);
        check_time("rst2", 0, 0, 0);
        rst = 1'b0;
        step(3);
        check("rst2.tick3", int'(tick), 1);
        check("rst2.sec3", int'(sec), 0);
        step(1);
        check("rst2.sec4", int'(sec), 1);
        step(10);
        check("rst2.held", int'(mode), 0);
        sw_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
